pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//   Parametrised chain of STAGES pipeline registers carrying a WIDTH-bit payload, with per-stage valid bits.
//   Supports per-stage stall (hold), per-stage flush (kill younger), bubble insertion and bubble collapsing.
//   Downstream backpressure is via out_ready. Replaces hand-written IF/ID..MEM/WB registers in later cores.
//   Stage 0 is youngest (fed from in_*); stage STAGES-1 is oldest (drives out_*).
// PARAMETERS
//   WIDTH         32   payload bits per stage
//   STAGES        4    number of register stages; legal range 2..16
//   BUBBLE_VALUE  0    payload loaded into a stage when it becomes empty (WIDTH bits)
// PORTS
//   clock       in   1               system clock; all state updates on posedge
//   reset       in   1               synchronous, active-low; reset==0 at posedge clears all state
//   in_valid    in   1               producer presents in_data this cycle
//   in_data     in   WIDTH           payload entering stage 0
//   in_ready    out  1               stage 0 accepts in_data at this edge (combinational)
//   stall_req   in   STAGES          bit i: stage i must hold its contents this cycle
//   flush_req   in   STAGES          bit i: discard contents of stages 0..i this cycle
//   out_ready   in   1               consumer accepts the stage STAGES-1 payload
//   out_valid   out  1               = valid[STAGES-1]
//   out_data    out  WIDTH           = data[STAGES-1]
//   stage_valid out  STAGES          valid bit of every stage, registered
//   stage_data  out  STAGES*WIDTH    stage i at [i*WIDTH +: WIDTH], registered
//   stage_load  out  STAGES          bit i: stage i loads from its upstream this edge (combinational)
//   occupancy   out  $clog2(STAGES+1)  count of valid stages, registered
// BEHAVIOUR
//   Reset (reset==0): all valid=0, all data=BUBBLE_VALUE, occupancy=0. Inputs are ignored that cycle.
//   Block chain, combinational, computed from oldest to youngest:
//     blk[N-1] = stall_req[N-1] | (valid[N-1] & ~out_ready)
//     blk[i]   = stall_req[i]   | (valid[i] & blk[i+1])
//   A stall on an empty stage still blocks upstream.
//   stage_load[i] = ~blk[i]. in_ready = ~blk[0] & ~|flush_req.
//   Per-stage update when not flushed:
//     blk[i]=1 -> hold.
//     else if i>0 -> take valid/data of stage i-1.
//       If blk[i-1]=1, load a bubble instead: valid=0, data=BUBBLE_VALUE.
//     else (stage 0) -> take in_valid & in_ready with in_data; if not accepted, load a bubble.
//   An empty stage never blocks, so bubbles collapse under backpressure.
//   Flush: let f = highest set index of flush_req.
//     Stages 0..f load a bubble regardless of stall_req; flush wins over stall.
//     If stage f+1 would load from stage f, it loads a bubble.
//     Stages above f+1 follow the normal rules.
//   Output handshake: a transfer occurs when out_valid & out_ready.
//     Data is held stable while out_valid=1 and out_ready=0.
//   Latency: with no stalls, an item accepted at edge t appears on out_* after edge t+STAGES-1.
//     That is, STAGES edges after presentation.
//   Throughput is 1 item/cycle when fully unstalled.
//   occupancy: next-state popcount of valid; always in range 0..STAGES.
//   No state machine beyond the valid bits. No wrap-around. Payload is never modified except by bubble replacement.
// TESTING  (WIDTH=32, STAGES=4, BUBBLE_VALUE=0)
//   1. Stream: release reset; in_valid=1 with data 1,2,...,8; out_ready=1.
//      -> out_data 1..8 in order; first out_valid 4 edges after 1 presented; occupancy steady at 4; in_ready=1 throughout.
//   2. Stall: pipe full with A,B,C,D (D oldest); stall_req=4'b0010 for 2 cycles.
//      -> stages 0,1 hold; stage 2 gets valid=0/data=0 twice; in_ready=0 for 2 cycles; D,C drain; no item lost or duplicated.
//   3. Collapse: out_ready=0; feed 0x11, gap, 0x22, gap, 0x33, 0x44.
//      -> all 4 accepted; stage_valid=4'b1111; then in_ready=0; out_data=0x11 held until out_ready=1.
//   4. Flush: pipe full A,B,C,D; flush_req=4'b0100 with out_ready=1.
//      -> D transfers out; next cycle stage_valid=4'b0000, occupancy=0; in_ready=0 during the flush cycle.
//   5. Flush+stall: stall_req=4'b0001 and flush_req=4'b0001 together.
//      -> stage 0 becomes bubble (flush wins); stages 1..3 advance normally.
//   6. Reset mid-stream: drive reset=0 for 1 cycle with 3 valid items.
//      -> after edge all stage_valid=0, stage_data=0, out_valid=0, occupancy=0; none of the 3 items ever appear on out_*.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Generic valid/data pipeline register chain with stall, flush,
// bubble insertion and bubble collapsing under backpressure.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  input  logic [STAGES-1:0]            stall_req,
  input  logic [STAGES-1:0]            flush_req,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic [STAGES-1:0]            stage_load,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OW = $clog2(STAGES+1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] blk, fl;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [OW-1:0]     occ_q, occ_d;

  // fl[i]: some flush bit at index >= i, so stage i is discarded
  always_comb begin : blk_chain
    logic b;
    logic f;
    b = stall_req[STAGES-1]
      | (valid_q[STAGES-1] & ~out_ready);
    f = flush_req[STAGES-1];
    blk = '0;
    fl  = '0;
    blk[STAGES-1] = b;
    fl[STAGES-1]  = f;
    for (int i = STAGES-2; i >= 0; i--) begin
      b = stall_req[i] | (valid_q[i] & b);
      f = f | flush_req[i];
      blk[i] = b;
      fl[i]  = f;
    end
  end

  assign in_ready   = ~blk[0] & ~|flush_req;
  assign stage_load = ~blk;

  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    occ_d   = '0;
    if (fl[0]) begin
      valid_d[0] = 1'b0;
      data_d[0]  = BUBBLE_VALUE;
    end else if (!blk[0]) begin
      valid_d[0] = in_valid & in_ready;
      data_d[0]  = (in_valid & in_ready) ? in_data
                                         : BUBBLE_VALUE;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (fl[i]) begin
        valid_d[i] = 1'b0;
        data_d[i]  = BUBBLE_VALUE;
      end else if (!blk[i]) begin
        if (valid_q[i-1] & ~blk[i-1] & ~fl[i-1]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = data_q[i-1];
        end else begin
          valid_d[i] = 1'b0;
          data_d[i]  = BUBBLE_VALUE;
        end
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OW'(valid_d[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= BUBBLE_VALUE;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin : pack_out
    stage_data = '0;
    for (int i = 0; i < STAGES; i++) begin
      stage_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed table-driven bench for pipe_stage_chain
// (WIDTH=32, STAGES=4, BUBBLE_VALUE=0).
module tb_pipe_stage_chain;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [3:0]   stall_req;
  logic [3:0]   flush_req;
  logic         out_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [3:0]   stage_valid;
  logic [127:0] stage_data;
  logic [3:0]   stage_load;
  logic [2:0]   occupancy;

  pipe_stage_chain #(
    .WIDTH(32),
    .STAGES(4),
    .BUBBLE_VALUE(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .stall_req(stall_req),
    .flush_req(flush_req),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .stage_valid(stage_valid),
    .stage_data(stage_data),
    .stage_load(stage_load),
    .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         rst_n;
    logic         iv;
    logic [31:0]  id;
    logic [3:0]   st;
    logic [3:0]   fl;
    logic         ordy;
    logic         ck_ir;
    logic         e_ir;
    logic         e_ov;
    logic [31:0]  e_od;
    logic [3:0]   e_sv;
    logic [2:0]   e_occ;
    logic         ck_sl;
    logic [3:0]   e_sl;
    logic         ck_sd;
    logic [127:0] e_sd;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(
    input logic rst_n, input logic iv,
    input logic [31:0] id, input logic [3:0] st,
    input logic [3:0] fl, input logic ordy,
    input logic ck_ir, input logic e_ir,
    input logic e_ov, input logic [31:0] e_od,
    input logic [3:0] e_sv, input logic [2:0] e_occ,
    input logic ck_sl = 1'b0,
    input logic [3:0] e_sl = 4'h0,
    input logic ck_sd = 1'b0,
    input logic [127:0] e_sd = 128'h0
  );
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.id = id;
    v.st = st; v.fl = fl; v.ordy = ordy;
    v.ck_ir = ck_ir; v.e_ir = e_ir;
    v.e_ov = e_ov; v.e_od = e_od;
    v.e_sv = e_sv; v.e_occ = e_occ;
    v.ck_sl = ck_sl; v.e_sl = e_sl;
    v.ck_sd = ck_sd; v.e_sd = e_sd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset     = v.rst_n;
    in_valid  = v.iv;
    in_data   = v.id;
    stall_req = v.st;
    flush_req = v.fl;
    out_ready = v.ordy;
    #1;
    if (v.ck_ir) chk("in_ready", idx, in_ready, v.e_ir);
    if (v.ck_sl) chk("stage_load", idx, stage_load, v.e_sl);
    @(posedge clock);
    #1;
    chk("out_valid", idx, out_valid, v.e_ov);
    chk("out_data", idx, out_data, v.e_od);
    chk("stage_valid", idx, stage_valid, v.e_sv);
    chk("occupancy", idx, occupancy, v.e_occ);
    if (v.ck_sd) chk("stage_data", idx, stage_data, v.e_sd);
  endtask

  // Oldest-first feed with out_ready low: ends with D in stage 3, A in stage 0
  task automatic fill_dcba();
    tbl.push_back(mk(1,1,32'hD,0,0,0, 1,1, 0,0,4'h1,1));
    tbl.push_back(mk(1,1,32'hC,0,0,0, 1,1, 0,0,4'h3,2));
    tbl.push_back(mk(1,1,32'hB,0,0,0, 1,1, 0,0,4'h7,3));
    tbl.push_back(mk(1,1,32'hA,0,0,0, 1,1, 1,32'hD,4'hF,4));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    stall_req = '0;
    flush_req = '0;
    out_ready = 1'b0;

    // reset, inputs ignored
    tbl.push_back(mk(0,1,32'hDEAD,0,0,1, 0,0, 0,0,4'h0,0, 0,0, 1,128'h0));
    tbl.push_back(mk(0,1,32'hBEEF,4'hF,4'hF,0, 0,0, 0,0,4'h0,0, 0,0, 1,128'h0));

    // stream 1..8 then drain
    tbl.push_back(mk(1,1,32'd1,0,0,1, 1,1, 0,32'd0,4'h1,1));
    tbl.push_back(mk(1,1,32'd2,0,0,1, 1,1, 0,32'd0,4'h3,2));
    tbl.push_back(mk(1,1,32'd3,0,0,1, 1,1, 0,32'd0,4'h7,3));
    tbl.push_back(mk(1,1,32'd4,0,0,1, 1,1, 1,32'd1,4'hF,4));
    tbl.push_back(mk(1,1,32'd5,0,0,1, 1,1, 1,32'd2,4'hF,4));
    tbl.push_back(mk(1,1,32'd6,0,0,1, 1,1, 1,32'd3,4'hF,4));
    tbl.push_back(mk(1,1,32'd7,0,0,1, 1,1, 1,32'd4,4'hF,4));
    tbl.push_back(mk(1,1,32'd8,0,0,1, 1,1, 1,32'd5,4'hF,4));
    tbl.push_back(mk(1,0,32'd0,0,0,1, 1,1, 1,32'd6,4'hE,3));
    tbl.push_back(mk(1,0,32'd0,0,0,1, 1,1, 1,32'd7,4'hC,2));
    tbl.push_back(mk(1,0,32'd0,0,0,1, 1,1, 1,32'd8,4'h8,1));
    tbl.push_back(mk(1,0,32'd0,0,0,1, 1,1, 0,32'd0,4'h0,0));

    // stall stage 1 for two cycles
    fill_dcba();
    tbl.push_back(mk(1,1,32'hE,4'h2,0,1, 1,0, 1,32'hC,4'hB,3,
                     1,4'hC, 1,{32'hC,32'h0,32'hB,32'hA}));
    tbl.push_back(mk(1,1,32'hE,4'h2,0,1, 1,0, 0,32'h0,4'h3,2,
                     1,4'hC, 1,{32'h0,32'h0,32'hB,32'hA}));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 0,32'h0,4'h6,2));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 1,32'hB,4'hC,2));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 1,32'hA,4'h8,1));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 0,32'h0,4'h0,0));

    // bubble collapse under backpressure
    tbl.push_back(mk(1,1,32'h11,0,0,0, 1,1, 0,32'h0,4'h1,1));
    tbl.push_back(mk(1,0,32'h0,0,0,0, 1,1, 0,32'h0,4'h2,1));
    tbl.push_back(mk(1,1,32'h22,0,0,0, 1,1, 0,32'h0,4'h5,2));
    tbl.push_back(mk(1,0,32'h0,0,0,0, 1,1, 1,32'h11,4'hA,2));
    tbl.push_back(mk(1,1,32'h33,0,0,0, 1,1, 1,32'h11,4'hD,3, 1,4'h7));
    tbl.push_back(mk(1,1,32'h44,0,0,0, 1,1, 1,32'h11,4'hF,4, 1,4'h3));
    tbl.push_back(mk(1,1,32'h55,0,0,0, 1,0, 1,32'h11,4'hF,4,
                     1,4'h0, 1,{32'h11,32'h22,32'h33,32'h44}));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 1,32'h22,4'hE,3, 1,4'hF));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 1,32'h33,4'hC,2));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 1,32'h44,4'h8,1));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 0,32'h0,4'h0,0));

    // flush through stage 2 while D leaves
    fill_dcba();
    tbl.push_back(mk(1,1,32'hE,0,4'h4,1, 1,0, 0,32'h0,4'h0,0,
                     1,4'hF, 1,128'h0));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 0,32'h0,4'h0,0));

    // flush and stall on stage 0 together
    fill_dcba();
    tbl.push_back(mk(1,0,32'h0,4'h1,4'h1,1, 1,0, 1,32'hC,4'hC,2,
                     1,4'hE, 1,{32'hC,32'hB,32'h0,32'h0}));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 1,32'hB,4'h8,1));
    tbl.push_back(mk(1,0,32'h0,0,0,1, 1,1, 0,32'h0,4'h0,0));

    // reset with three items in flight
    tbl.push_back(mk(1,1,32'h61,0,0,1, 1,1, 0,32'h0,4'h1,1));
    tbl.push_back(mk(1,1,32'h62,0,0,1, 1,1, 0,32'h0,4'h3,2));
    tbl.push_back(mk(1,1,32'h63,0,0,1, 1,1, 0,32'h0,4'h7,3));
    tbl.push_back(mk(0,1,32'h64,0,0,1, 0,0, 0,32'h0,4'h0,0,
                     0,4'h0, 1,128'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // none of the reset-killed items may ever surface
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    stall_req = '0;
    flush_req = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      chk("post_reset_out_valid", 1000 + c, out_valid, 1'b0);
      chk("post_reset_occupancy", 1000 + c, occupancy, 3'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end

endmodule
